// File: rtl/header_extractor_pkg.sv
// Shared definitions for the IPv4 header extractor: FSM states, header
// offsets and the L4 protocol numbers that carry port fields.
package header_extractor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        OPTS,
        PORTS,
        SKIP,
        HOLD
    } state_t;

    localparam logic [6:0] PROTO_OFF    = 7'd9;
    localparam logic [6:0] SRC_IP_OFF   = 7'd12;
    localparam logic [6:0] DST_IP_OFF   = 7'd16;
    localparam logic [6:0] HDR_LAST_OFF = 7'd19;
    localparam logic [6:0] BYTE_CNT_MAX = 7'd127;

    localparam logic [7:0] PROTO_TCP = 8'd6;
    localparam logic [7:0] PROTO_UDP = 8'd17;

    function automatic logic is_l4(input logic [7:0] proto);
        return (proto == PROTO_TCP) || (proto == PROTO_UDP);
    endfunction

endpackage

// File: rtl/header_extractor.sv
// Parses an IPv4 byte stream into a {src_ip, dst_ip, protocol} + L4 port tuple
// and presents it with valid/ready; malformed or truncated packets are counted.
module header_extractor
    import header_extractor_pkg::*;
#(
    parameter int unsigned DROP_CNT_W  = 16,
    parameter bit          PASS_NON_L4 = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    input  logic                  in_sop,
    input  logic                  in_eop,
    output logic                  in_ready,
    output logic [71:0]           ip_protocol,
    output logic [15:0]           src_port,
    output logic [15:0]           dst_port,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DROP_CNT_W-1:0] drop_count
);

    state_t      state, state_next;
    logic [6:0]  byte_cnt;
    logic [3:0]  ihl_q;
    logic        bad_q;
    logic        hdr_done_q;
    logic        ports_done_q;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [7:0]  protocol;

    logic        accept;
    logic        active;
    logic [6:0]  hdr_len;
    logic [1:0]  port_idx;
    logic        l4;
    logic        hdr_done_now;
    logic        ports_done_now;
    logic        good;
    logic        drop_old;
    logic        drop_new;
    logic [1:0]  drop_amt;
    logic [DROP_CNT_W:0] drop_sum;

    assign ip_protocol = {src_ip, dst_ip, protocol};
    assign in_ready    = (state != HOLD);
    assign out_valid   = (state == HOLD);
    assign accept      = in_valid && in_ready;
    assign active      = state inside {HDR, OPTS, PORTS, SKIP};
    assign hdr_len     = {1'b0, ihl_q, 2'b00};
    assign port_idx    = 2'(byte_cnt - hdr_len);
    assign l4          = is_l4(protocol);

    // Completion includes the byte being accepted this cycle, so an eop on the
    // last required byte still yields a good packet.
    assign hdr_done_now   = hdr_done_q || (state == HDR && byte_cnt == HDR_LAST_OFF);
    assign ports_done_now = ports_done_q || (state == PORTS && port_idx == 2'd3);
    assign good           = !bad_q && hdr_done_now && (l4 ? ports_done_now : PASS_NON_L4);

    assign drop_amt = {1'b0, drop_old} + {1'b0, drop_new};
    assign drop_sum = {1'b0, drop_count} + (DROP_CNT_W+1)'(drop_amt);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        drop_old   = 1'b0;
        drop_new   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && in_sop) begin
                    if (in_eop) drop_new = 1'b1;
                    else        state_next = HDR;
                end
            end
            HOLD: begin
                if (out_ready) state_next = IDLE;
            end
            default: begin
                if (accept) begin
                    if (in_sop) begin
                        drop_old = 1'b1;
                        if (in_eop) begin
                            drop_new   = 1'b1;
                            state_next = IDLE;
                        end else begin
                            state_next = HDR;
                        end
                    end else if (in_eop) begin
                        if (good) begin
                            state_next = HOLD;
                        end else begin
                            drop_old   = 1'b1;
                            state_next = IDLE;
                        end
                    end else begin
                        case (state)
                            HDR: begin
                                if (byte_cnt == HDR_LAST_OFF) begin
                                    if (bad_q)              state_next = SKIP;
                                    else if (ihl_q > 4'd5)  state_next = OPTS;
                                    else if (l4)            state_next = PORTS;
                                    else                    state_next = SKIP;
                                end
                            end
                            OPTS: begin
                                if (byte_cnt == hdr_len - 7'd1)
                                    state_next = l4 ? PORTS : SKIP;
                            end
                            PORTS: begin
                                if (port_idx == 2'd3) state_next = SKIP;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt     <= '0;
            ihl_q        <= '0;
            bad_q        <= 1'b0;
            hdr_done_q   <= 1'b0;
            ports_done_q <= 1'b0;
            protocol     <= '0;
            src_ip       <= '0;
            dst_ip       <= '0;
            src_port     <= '0;
            dst_port     <= '0;
            drop_count   <= '0;
        end else begin
            if (drop_sum[DROP_CNT_W]) drop_count <= '1;
            else                      drop_count <= drop_sum[DROP_CNT_W-1:0];

            if (accept && in_sop) begin
                // This byte is offset 0 of a new packet, whatever came before.
                ihl_q        <= in_data[3:0];
                bad_q        <= (in_data[7:4] != 4'd4) || (in_data[3:0] < 4'd5);
                byte_cnt     <= 7'd1;
                hdr_done_q   <= 1'b0;
                ports_done_q <= 1'b0;
                src_port     <= '0;
                dst_port     <= '0;
            end else if (accept && active) begin
                if (byte_cnt != BYTE_CNT_MAX) byte_cnt <= byte_cnt + 7'd1;

                if (state == HDR) begin
                    if (byte_cnt == PROTO_OFF)
                        protocol <= in_data;
                    if (byte_cnt >= SRC_IP_OFF && byte_cnt < DST_IP_OFF)
                        src_ip <= {src_ip[23:0], in_data};
                    if (byte_cnt >= DST_IP_OFF && byte_cnt <= HDR_LAST_OFF)
                        dst_ip <= {dst_ip[23:0], in_data};
                    if (byte_cnt == HDR_LAST_OFF)
                        hdr_done_q <= 1'b1;
                end

                if (state == PORTS) begin
                    if (!port_idx[1]) src_port <= {src_port[7:0], in_data};
                    else              dst_port <= {dst_port[7:0], in_data};
                    if (port_idx == 2'd3) ports_done_q <= 1'b1;
                end

                if (in_eop) byte_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/header_extractor.md
HEADER_EXTRACTOR -- requirements
Module: header_extractor

Interface
REQ-001 Parameter DROP_CNT_W, default 16: width of the drop counter.
REQ-002 Parameter PASS_NON_L4, default 1: 1 forwards non-TCP/UDP packets with zero ports; 0 drops them.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_data  input  8  packet byte stream; byte 0 is the first IPv4 header byte.
REQ-007 in_valid  input  1  in_data/in_sop/in_eop valid.
REQ-008 in_sop  input  1  first byte of packet.
REQ-009 in_eop  input  1  last byte of packet.
REQ-010 in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-011 ip_protocol  output  72  packed {src_ip[31:0], dst_ip[31:0], protocol[7:0]}.
REQ-012 src_port  output  16  L4 source port, big-endian from stream.
REQ-013 dst_port  output  16  L4 destination port, big-endian from stream.
REQ-014 out_valid  output  1  tuple valid; driven to the firewall stage.
REQ-015 out_ready  input  1  firewall ready-to-receive; tuple transfers when out_valid && out_ready.
REQ-016 drop_count  output  DROP_CNT_W  saturating count of discarded packets.

Function
REQ-017 States: IDLE, HDR, OPTS, PORTS, SKIP, HOLD.
REQ-018 in_ready shall be 1 in every state except HOLD.
REQ-019 IDLE: an accepted byte with in_sop=1 goes to HDR and sets byte_cnt=1; accepted bytes with in_sop=0 are discarded without counting.
REQ-020 HDR, byte 0: version=in_data[7:4] and ihl=in_data[3:0] are captured; version!=4 or ihl<5 marks the packet bad.
REQ-021 HDR: byte 9 captures protocol, bytes 12-15 capture src_ip, and bytes 16-19 capture dst_ip (MSB first).
REQ-022 After byte 19, the block goes to OPTS if ihl>5, else to PORTS; OPTS consumes bytes up to offset ihl*4-1.
REQ-023 PORTS: bytes ihl*4 .. ihl*4+3 capture src_port then dst_port; this happens only for protocol 6 or 17, otherwise the ports are 0 and the state goes straight to SKIP.
REQ-024 SKIP consumes bytes until in_eop; bytes after the ports are ignored.
REQ-025 The accepted byte carrying in_eop ends the packet in any state; a good, complete packet goes to HOLD the next cycle, and out_valid=1 on the cycle after eop acceptance (latency 1).
REQ-026 Truncation: eop before the required fields are captured (byte 19, plus ports for TCP/UDP) drops the packet.
REQ-027 A bad packet is dropped at its eop and the state returns to IDLE.
REQ-028 A non-L4 packet with PASS_NON_L4=0 is dropped at its eop and the state returns to IDLE.
REQ-029 Each drop increments drop_count, which saturates at all-ones.
REQ-030 in_sop arriving in a non-IDLE state other than HOLD drops the current packet (count +1) and restarts HDR with that byte as byte 0.
REQ-031 HOLD: ip_protocol/src_port/dst_port/out_valid shall be held stable until out_ready=1; on transfer, next state is IDLE and out_valid=0 the next cycle.
REQ-032 byte_cnt is 7 bits and saturates at 127; packets longer than 127 bytes are handled by SKIP.
REQ-033 Outputs change only in HDR/PORTS capture or on reset, never while out_valid=1.

Reset
REQ-034 On reset the state shall be IDLE, and out_valid=0, ip_protocol=0, src_port=0, dst_port=0, drop_count=0, byte_cnt=0.
REQ-035 in_ready=1 the cycle after reset deasserts.
REQ-036 Reset mid-packet or in HOLD shall abandon the tuple without counting a drop.

Structure
REQ-037 Shared package holds the state enum, the IPv4 offsets (PROTO_OFF=9, SRC_IP_OFF=12, DST_IP_OFF=16), and the PROTO_TCP=6 and PROTO_UDP=17 constants.
REQ-038 Single module, no sub-modules; a drop counter is the only natural helper, and it shall be inlined.

Verification
REQ-039 20-byte IPv4 UDP packet (45.., proto 0x11, src 0A000001, dst 0A000002) plus ports 0x1234/0x0050, eop on byte 27, out_ready=1 -> out_valid one cycle after eop; ip_protocol=0A000001_0A000002_11, src_port=1234, dst_port=0050.
REQ-040 Packet with ihl=6 and TCP -> ports taken from bytes 24-27, the 4 option bytes ignored.
REQ-041 Packet with version 6 -> no out_valid, drop_count=1.
REQ-042 Packet with eop at byte 15 -> drop_count=1; state IDLE.
REQ-042a Packet with new sop at byte 10 -> drop_count=1, and the second packet parses correctly.
REQ-043 out_ready=0 for 5 cycles after tuple -> in_ready=0 and outputs stable throughout; transfer on cycle 6; in_ready=1 next.
REQ-044 ICMP packet (proto 1) -> tuple with ports 0 when PASS_NON_L4=1; drop_count+1 when PASS_NON_L4=0.
